ram_responder: RTL and testbench

RAM_RESPONDER -- requirements
Module: ram_responder

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/ram_array.sv | 37 +++
 rtl/ram_responder.sv | 116 +++++++++++
 tb/tb_ram_responder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// ============================================================================
// cpu_types_pkg : shared word type and the responder state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } ram_state_t;

endpackage

`default_nettype wire

// File: rtl/ram_array.sv
// ============================================================================
// ram_array : word storage with per-byte write enables and asynchronous read
// Rev 1.0
// ============================================================================
`default_nettype none

module ram_array
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  word_t         wdata,
  input  logic [AW-1:0] raddr,
  output word_t         rdata
);

  word_t mem [DEPTH];

  // Contents are intentionally never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/ram_responder.sv
// ============================================================================
// ram_responder : fixed-latency request/busy RAM front end (IDLE/ACCESS/DONE)
// Optional build macro RAM_BYTE_EN adds the ram_be byte-lane write mask.
// Rev 1.0
// ============================================================================
`default_nettype none

module ram_responder
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int LAT   = 2
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       Ren,
  input  logic       Wen,
  input  word_t      ramaddr,
  input  word_t      ramstore,
`ifdef RAM_BYTE_EN
  input  logic [3:0] ram_be,
`endif
  output word_t      ramload,
  output logic       busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LAT + 1);

  ram_state_t    state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] idx;
  word_t         data;
  logic          op_wr;
  logic [3:0]    be;

  logic          req;
  logic [3:0]    be_in;
  logic [AW-1:0] rd_idx;
  word_t         rd_data;
  logic          mem_we;
  logic          unused_addr_bits;

  assign req    = Ren | Wen;
  assign busy_o = nRST & req & (state != DONE);
  assign mem_we = (state == DONE) & op_wr;

  // With LAT=1 the read completes straight out of IDLE, before idx is latched.
  assign rd_idx = (state == IDLE) ? ramaddr[AW+1:2] : idx;

  assign unused_addr_bits = ^{ramaddr[31:AW+2], ramaddr[1:0]};

`ifdef RAM_BYTE_EN
  assign be_in = ram_be;
`else
  assign be_in = 4'hF;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      data    <= '0;
      op_wr   <= 1'b0;
      be      <= '0;
      ramload <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            idx   <= ramaddr[AW+1:2];
            data  <= ramstore;
            op_wr <= Wen;
            be    <= be_in;
            cnt   <= CW'(LAT - 1);
            if (LAT == 1) begin
              state <= DONE;
              if (!Wen) ramload <= rd_data;
            end else begin
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!req) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              state <= DONE;
              if (!op_wr) ramload <= rd_data;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  ram_array #(
    .DEPTH (DEPTH)
  ) u_ram_array (
    .clk   (CLK),
    .we    (mem_we),
    .be    (be),
    .waddr (idx),
    .wdata (data),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_ram_responder.sv
// ============================================================================
// tb_ram_responder : randomized self-checking bench for ram_responder
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ram_responder;
  import cpu_types_pkg::*;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic  CLK = 1'b0;
  logic  nRST = 1'b0;
  logic  Ren = 1'b0;
  logic  Wen = 1'b0;
  word_t ramaddr = '0;
  word_t ramstore = '0;
  word_t ramload;
  logic  busy_o;
`ifdef RAM_BYTE_EN
  logic [3:0] ram_be = 4'hF;
`endif

  ram_responder #(.DEPTH(DEPTH), .LAT(LAT)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .Ren      (Ren),
    .Wen      (Wen),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
`ifdef RAM_BYTE_EN
    .ram_be   (ram_be),
`endif
    .ramload  (ramload),
    .busy_o   (busy_o)
  );

  always #5 CLK = ~CLK;

  word_t ref_mem [DEPTH];
  word_t last_load;
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic check(input string tag, input word_t got, input word_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int widx(input word_t a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic word_t merge(input word_t old, input word_t d, input logic [3:0] be);
    word_t r = old;
`ifdef RAM_BYTE_EN
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
`else
    if (be == be) r = d;
`endif
    return r;
  endfunction

  // One complete access; address/data are scrambled once latched.
  task automatic txn(input bit wr, input bit rd, input word_t addr, input word_t d,
                     input logic [3:0] be, input bit drop_in_done);
    int i;
    i = widx(addr);
    Ren = rd; Wen = wr; ramaddr = addr; ramstore = d;
`ifdef RAM_BYTE_EN
    ram_be = be;
`endif
    for (int k = 0; k <= LAT; k++) begin
      @(negedge CLK);
      if (k < LAT) check("busy_pending", busy_o, 32'd1);
      else begin
        check("busy_done", busy_o, 32'd0);
        if (!wr) begin
          last_load = ref_mem[i];
          check("load_data", ramload, last_load);
        end else begin
          check("load_hold", ramload, last_load);
        end
        if (drop_in_done) begin Ren = 1'b0; Wen = 1'b0; end
      end
      @(posedge CLK); #1;
      if (k == 0) begin
        ramaddr = $urandom; ramstore = $urandom;
`ifdef RAM_BYTE_EN
        ram_be = 4'($urandom);
`endif
      end
    end
    Ren = 1'b0; Wen = 1'b0;
    if (wr) ref_mem[i] = merge(ref_mem[i], d, be);
  endtask

  task automatic abort_write(input word_t addr, input word_t d);
    Wen = 1'b1; Ren = 1'b0; ramaddr = addr; ramstore = d;
`ifdef RAM_BYTE_EN
    ram_be = 4'hF;
`endif
    @(negedge CLK); check("abort_busy_req", busy_o, 32'd1);
    @(posedge CLK); #1; Wen = 1'b0;
    @(negedge CLK); check("abort_busy_drop", busy_o, 32'd0);
    check("abort_load", ramload, last_load);
    @(posedge CLK); #1;
  endtask

  task automatic reset_mid_write(input word_t addr, input word_t d);
    Wen = 1'b1; Ren = 1'b0; ramaddr = addr; ramstore = d;
    @(posedge CLK); #1;
    nRST = 1'b0; #1;
    check("rst_busy", busy_o, 32'd0);
    check("rst_load", ramload, 32'd0);
    @(posedge CLK); #1;
    check("rst_busy_hold", busy_o, 32'd0);
    Wen = 1'b0; nRST = 1'b1;
    last_load = '0;
  endtask

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    int op;
    Ren = 1'b1;
    #12;
    check("reset_busy", busy_o, 32'd0);
    check("reset_load", ramload, 32'd0);
    Ren = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    last_load = '0;

    for (int a = 0; a < DEPTH; a++) txn(1'b1, 1'b0, word_t'(a * 4), $urandom, 4'hF, 1'b0);

    txn(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    txn(1'b0, 1'b1, 32'h10, 32'h0, 4'hF, 1'b0);
    check("rd_deadbeef", ramload, 32'hDEADBEEF);

    txn(1'b1, 1'b1, 32'h20, 32'h12345678, 4'hF, 1'b0);
    txn(1'b0, 1'b1, 32'h20, 32'h0, 4'hF, 1'b1);
    check("both_is_write", ramload, 32'h12345678);

    txn(1'b1, 1'b0, 32'h1004, 32'hA5A5A5A5, 4'hF, 1'b0);
    txn(1'b0, 1'b1, 32'h0004, 32'h0, 4'hF, 1'b0);
    check("wrap_read", ramload, 32'hA5A5A5A5);
    txn(1'b0, 1'b1, 32'h0006, 32'h0, 4'hF, 1'b0);
    check("low_bits_ignored", ramload, 32'hA5A5A5A5);

    abort_write(32'h30, ~ref_mem[widx(32'h30)]);
    txn(1'b0, 1'b1, 32'h30, 32'h0, 4'hF, 1'b0);

`ifdef RAM_BYTE_EN
    txn(1'b1, 1'b0, 32'h50, 32'h11223344, 4'hF, 1'b0);
    txn(1'b1, 1'b0, 32'h50, 32'hAABBCCDD, 4'b0101, 1'b0);
    txn(1'b0, 1'b1, 32'h50, 32'h0, 4'hF, 1'b0);
    check("byte_en_merge", ramload, 32'h11BB33DD);
`endif

    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 9);
      if (op == 0) abort_write($urandom, $urandom);
      else if (op <= 4) txn(1'b1, 1'b0, $urandom, $urandom, 4'($urandom), 1'($urandom));
      else if (op == 5) txn(1'b1, 1'b1, $urandom, $urandom, 4'($urandom), 1'($urandom));
      else txn(1'b0, 1'b1, $urandom, $urandom, 4'hF, 1'($urandom));
    end

    reset_mid_write(32'h40, ~ref_mem[widx(32'h40)]);
    txn(1'b0, 1'b1, 32'h40, 32'h0, 4'hF, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
